// File: rtl/spi_sample_reader.sv
// spi_sample_reader: periodically reads the 16-bit X-axis sample from an SPI
// sensor (mode 0, 24-bit frame: 8-bit command, lo byte, hi byte) and presents
// it on data_x together with an update_clk strobe for the processing block.
module spi_sample_reader #(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 10000,
    parameter logic [5:0] REG_ADDR      = 6'h28,
    parameter int         UPD_HIGH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] data_x,
    output logic        update_clk,
    output logic        busy,
    output logic        overrun
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int UW = (UPD_HIGH > 1) ? $clog2(UPD_HIGH) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [UW-1:0] UPD_LAST   = UW'(UPD_HIGH - 1);
    localparam logic [4:0]    LAST_BIT   = 5'd23;

    // Command byte: read, auto-increment, register address.
    localparam logic [7:0] CMD = {1'b1, 1'b1, REG_ADDR};

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CS_SETUP = 2'd1;
    localparam logic [1:0] SHIFT    = 2'd2;
    localparam logic [1:0] CS_HOLD  = 2'd3;

    logic [TW-1:0] timer;
    logic          tick;
    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [15:0]   rx_sr;
    logic          load_done;
    logic [UW-1:0] upd_cnt;

    // Sample timer: free-runs 0..SAMPLE_PERIOD-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!enable || timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign tick = enable && (timer == TIMER_LAST);

    // A tick that finds the FSM busy is lost; flag it in the same cycle.
    assign overrun = tick && (state != IDLE);

    // Transaction FSM: chip select framing, SCLK generation, MOSI/MISO shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            spi_sclk  <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            busy      <= 1'b0;
            data_x    <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= CS_SETUP;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        // First low phase begins: present command MSB.
                        state    <= SHIFT;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        spi_mosi <= CMD[7];
                        tx_sr    <= {CMD[6:0], 1'b0};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            // Rising SCLK edge: capture the sensor bit.
                            spi_sclk <= 1'b1;
                            rx_sr    <= {rx_sr[14:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                state    <= CS_HOLD;
                                spi_mosi <= 1'b0;
                            end else begin
                                // New low phase: next command bit (zeros after byte 0).
                                bit_cnt  <= bit_cnt + 5'd1;
                                spi_mosi <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        // rx_sr holds lo byte in [15:8] and hi byte in [7:0].
                        state     <= IDLE;
                        spi_cs_n  <= 1'b1;
                        busy      <= 1'b0;
                        data_x    <= {rx_sr[7:0], rx_sr[15:8]};
                        load_done <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // update_clk: rises the cycle after data_x loads, held for UPD_HIGH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_clk <= 1'b0;
            upd_cnt    <= '0;
        end else if (load_done) begin
            update_clk <= 1'b1;
            upd_cnt    <= '0;
        end else if (update_clk) begin
            if (upd_cnt == UPD_LAST) begin
                update_clk <= 1'b0;
            end else begin
                upd_cnt <= upd_cnt + 1'b1;
            end
        end
    end

endmodule
